// File: rtl/tlb_miss_arbiter_if.sv
// Bundle of TLB-miss, PTW-request and TLB-update signals between the two TLBs,
// the page-table walker and the miss arbiter. The arbiter takes the slave view.
interface tlb_miss_arbiter_if #(
  parameter int VLEN       = 39,
  parameter int ASID_WIDTH = 16
);
  logic                  flush_i;
  logic [ASID_WIDTH-1:0] asid_i;
  logic                  itlb_miss_i;
  logic [VLEN-1:0]       itlb_vaddr_i;
  logic                  dtlb_miss_i;
  logic [VLEN-1:0]       dtlb_vaddr_i;
  logic                  dtlb_is_store_i;
  logic                  ptw_req_valid_o;
  logic                  ptw_req_ready_i;
  logic [VLEN-1:0]       ptw_req_vaddr_o;
  logic [ASID_WIDTH-1:0] ptw_req_asid_o;
  logic                  ptw_req_is_store_o;
  logic                  ptw_req_src_o;
  logic                  ptw_done_i;
  logic                  ptw_error_i;
  logic                  itlb_update_valid_o;
  logic                  dtlb_update_valid_o;
  logic                  itlb_error_o;
  logic                  dtlb_error_o;
  logic                  busy_o;

  modport slave (
    input  flush_i, asid_i, itlb_miss_i, itlb_vaddr_i, dtlb_miss_i, dtlb_vaddr_i,
           dtlb_is_store_i, ptw_req_ready_i, ptw_done_i, ptw_error_i,
    output ptw_req_valid_o, ptw_req_vaddr_o, ptw_req_asid_o, ptw_req_is_store_o,
           ptw_req_src_o, itlb_update_valid_o, dtlb_update_valid_o, itlb_error_o,
           dtlb_error_o, busy_o
  );

  modport master (
    output flush_i, asid_i, itlb_miss_i, itlb_vaddr_i, dtlb_miss_i, dtlb_vaddr_i,
           dtlb_is_store_i, ptw_req_ready_i, ptw_done_i, ptw_error_i,
    input  ptw_req_valid_o, ptw_req_vaddr_o, ptw_req_asid_o, ptw_req_is_store_o,
           ptw_req_src_o, itlb_update_valid_o, dtlb_update_valid_o, itlb_error_o,
           dtlb_error_o, busy_o
  );
endinterface

// File: rtl/tlb_miss_arbiter.sv
// Shares one page-table walker between ITLB and DTLB misses: round-robin grant,
// request capture, walk tracking with flush/watchdog handling, and routing of
// the completion strobe back to the TLB that missed.
module tlb_miss_arbiter #(
  parameter int VLEN         = 39,
  parameter int ASID_WIDTH   = 16,
  parameter int WALK_TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  tlb_miss_arbiter_if.slave bus
);
  localparam int CW = (WALK_TIMEOUT > 2) ? $clog2(WALK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WALK_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WALK  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]            state, state_nxt;
  logic                  last_grant;
  logic [VLEN-1:0]       cap_vaddr;
  logic [ASID_WIDTH-1:0] cap_asid;
  logic                  cap_store;
  logic                  cap_src;
  logic [CW-1:0]         cnt;

  logic grant, pick_d, timeout, walk_live, upd, fault;

  // Round-robin only matters on a tie: the source that did not win last time goes.
  assign grant   = (state == S_IDLE) && !bus.flush_i && (bus.itlb_miss_i || bus.dtlb_miss_i);
  assign pick_d  = bus.dtlb_miss_i && (!bus.itlb_miss_i || !last_grant);
  assign timeout = (cnt == LIMIT);

  // A flush in the same cycle as done/timeout makes the result stale, so it gates every strobe.
  assign walk_live = (state == S_WALK) && !bus.flush_i;
  assign upd       = walk_live && bus.ptw_done_i && !bus.ptw_error_i;
  assign fault     = walk_live && ((bus.ptw_done_i && bus.ptw_error_i) ||
                                   (!bus.ptw_done_i && timeout));

  assign bus.itlb_update_valid_o = upd   && !cap_src;
  assign bus.dtlb_update_valid_o = upd   &&  cap_src;
  assign bus.itlb_error_o        = fault && !cap_src;
  assign bus.dtlb_error_o        = fault &&  cap_src;

  assign bus.ptw_req_valid_o    = (state == S_REQ);
  assign bus.ptw_req_vaddr_o    = cap_vaddr;
  assign bus.ptw_req_asid_o     = cap_asid;
  assign bus.ptw_req_is_store_o = cap_store;
  assign bus.ptw_req_src_o      = cap_src;
  assign bus.busy_o             = (state != S_IDLE);

  // Next-state: REQ flush with ready still owes the PTW a done, so it drains.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = S_REQ;
      S_REQ: begin
        if (bus.ptw_req_ready_i) state_nxt = bus.flush_i ? S_DRAIN : S_WALK;
        else if (bus.flush_i)    state_nxt = S_IDLE;
      end
      S_WALK: begin
        if (bus.ptw_done_i)                state_nxt = S_IDLE;
        else if (bus.flush_i || timeout)   state_nxt = S_DRAIN;
      end
      default: if (bus.ptw_done_i) state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Capture the winning request at grant; fields stay stable through REQ.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= 1'b0;
      cap_vaddr  <= '0;
      cap_asid   <= '0;
      cap_store  <= 1'b0;
      cap_src    <= 1'b0;
    end else if (grant) begin
      last_grant <= pick_d;
      cap_vaddr  <= pick_d ? bus.dtlb_vaddr_i : bus.itlb_vaddr_i;
      cap_asid   <= bus.asid_i;
      cap_store  <= pick_d && bus.dtlb_is_store_i;
      cap_src    <= pick_d;
    end
  end

  // Watchdog: cleared on the handshake into WALK, saturating count while walking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                                       cnt <= '0;
    else if (state == S_REQ && bus.ptw_req_ready_i && !bus.flush_i)   cnt <= '0;
    else if (state == S_WALK && !timeout)                              cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_tlb_miss_arbiter.sv
// Randomised scoreboard bench for tlb_miss_arbiter: the driver predicts every
// PTW handshake and every TLB strobe (with its cycle) into queues; a negedge
// monitor pops and compares whenever the DUT presents one.
module tb_tlb_miss_arbiter;
  localparam int VLEN = 39;
  localparam int AW   = 16;
  localparam int WT   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlb_miss_arbiter_if #(.VLEN(VLEN), .ASID_WIDTH(AW)) bus();
  tlb_miss_arbiter #(.VLEN(VLEN), .ASID_WIDTH(AW), .WALK_TIMEOUT(WT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );

  typedef struct { int cyc; logic src; logic [VLEN-1:0] va; logic [AW-1:0] asid; logic st; } req_t;
  typedef struct { int cyc; logic [3:0] vec; } stb_t;  // {iu, du, ie, de}

  req_t req_q[$];
  stb_t stb_q[$];
  int   checks = 0, errors = 0, cyc = 0;
  logic last = 1'b0;  // model: source granted most recently (1 = DTLB)

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: any strobe or handshake must match the head of its queue.
  logic [3:0] mon_v;
  stb_t       mon_s;
  req_t       mon_r;
  always @(negedge clk) if (rst_n) begin
    mon_v = {bus.itlb_update_valid_o, bus.dtlb_update_valid_o, bus.itlb_error_o, bus.dtlb_error_o};
    if (mon_v != 4'b0) begin
      if (stb_q.size() == 0) chk("strobe_unexpected", 64'(mon_v), 64'h0);
      else begin
        mon_s = stb_q.pop_front();
        chk("strobe_vec", 64'(mon_v), 64'(mon_s.vec));
        chk("strobe_cycle", 64'(cyc), 64'(mon_s.cyc));
      end
    end
    if (bus.ptw_req_valid_o && bus.ptw_req_ready_i) begin
      if (req_q.size() == 0) chk("req_unexpected", 64'h1, 64'h0);
      else begin
        mon_r = req_q.pop_front();
        chk("req_src", 64'(bus.ptw_req_src_o), 64'(mon_r.src));
        chk("req_vaddr", 64'(bus.ptw_req_vaddr_o), 64'(mon_r.va));
        chk("req_asid", 64'(bus.ptw_req_asid_o), 64'(mon_r.asid));
        chk("req_store", 64'(bus.ptw_req_is_store_o), 64'(mon_r.st));
        chk("req_cycle", 64'(cyc), 64'(mon_r.cyc));
      end
    end
  end

  task automatic drain(input int d, input logic e);
    for (int i = 0; i < d; i++) begin
      bus.flush_i = 1'($urandom_range(0, 1));
      tick();
      bus.flush_i = 1'b0;
      chk("drain_hold", 64'(bus.busy_o), 64'h1);
    end
    bus.ptw_done_i = 1'b1; bus.ptw_error_i = e;
    tick();
    bus.ptw_done_i = 1'b0; bus.ptw_error_i = 1'b0;
    chk("drain_exit", 64'(bus.busy_o), 64'h0);
  endtask

  // outc: 0 done, 1 done+flush, 2 flush in walk then drain, 3 timeout,
  //       4 flush in REQ without ready, 5 flush with ready in REQ
  task automatic txn(input logic im, input logic dm, input logic [VLEN-1:0] iva,
                     input logic [VLEN-1:0] dva, input logic st, input logic [AW-1:0] asid,
                     input bit fl_idle, input int rdel, input int outc, input int k,
                     input logic e, input int d);
    logic w; req_t r; stb_t s;
    bus.itlb_miss_i = im; bus.dtlb_miss_i = dm;
    bus.itlb_vaddr_i = iva; bus.dtlb_vaddr_i = dva;
    bus.dtlb_is_store_i = st; bus.asid_i = asid;
    chk("idle_not_busy", 64'(bus.busy_o), 64'h0);
    if (fl_idle) begin
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("idle_flush_blocks", 64'(bus.busy_o), 64'h0);
    end
    w = (im && dm) ? ~last : dm;
    last = w;
    r.src = w; r.va = w ? dva : iva; r.asid = asid; r.st = w ? st : 1'b0;
    tick();
    // Misses drop and inputs change after grant: the captured request must hold.
    bus.itlb_miss_i = 1'b0; bus.dtlb_miss_i = 1'b0;
    bus.itlb_vaddr_i = {$urandom, $urandom}; bus.dtlb_vaddr_i = {$urandom, $urandom};
    bus.asid_i = AW'($urandom); bus.dtlb_is_store_i = 1'($urandom);
    chk("req_valid", 64'(bus.ptw_req_valid_o), 64'h1);
    for (int i = 0; i < rdel; i++) begin
      tick();
      chk("req_valid_hold", 64'(bus.ptw_req_valid_o), 64'h1);
    end
    if (outc == 4) begin
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("abort_valid_drop", 64'(bus.ptw_req_valid_o), 64'h0);
      chk("abort_idle", 64'(bus.busy_o), 64'h0);
      return;
    end
    r.cyc = cyc;
    req_q.push_back(r);
    bus.ptw_req_ready_i = 1'b1;
    bus.flush_i = (outc == 5);
    tick();
    bus.ptw_req_ready_i = 1'b0; bus.flush_i = 1'b0;
    chk("walk_busy", 64'(bus.busy_o), 64'h1);
    case (outc)
      0, 1: begin
        repeat (k - 1) tick();
        if (outc == 0) begin
          s.cyc = cyc;
          s.vec = e ? (w ? 4'b0001 : 4'b0010) : (w ? 4'b0100 : 4'b1000);
          stb_q.push_back(s);
        end else bus.flush_i = 1'b1;
        bus.ptw_done_i = 1'b1; bus.ptw_error_i = e;
        tick();
        bus.ptw_done_i = 1'b0; bus.ptw_error_i = 1'b0; bus.flush_i = 1'b0;
        chk("done_to_idle", 64'(bus.busy_o), 64'h0);
      end
      2: begin
        repeat (k - 1) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        drain(d, e);
      end
      3: begin
        repeat (WT - 1) tick();
        s.cyc = cyc; s.vec = w ? 4'b0001 : 4'b0010;
        stb_q.push_back(s);
        tick();
        chk("timeout_drain", 64'(bus.busy_o), 64'h1);
        drain(d, e);
      end
      default: drain(d, e);
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    req_t rr;
    bus.flush_i = 0; bus.asid_i = 0; bus.itlb_miss_i = 0; bus.itlb_vaddr_i = 0;
    bus.dtlb_miss_i = 0; bus.dtlb_vaddr_i = 0; bus.dtlb_is_store_i = 0;
    bus.ptw_req_ready_i = 0; bus.ptw_done_i = 0; bus.ptw_error_i = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 64'(bus.busy_o), 64'h0);
    chk("rst_valid", 64'(bus.ptw_req_valid_o), 64'h0);
    chk("rst_vaddr", 64'(bus.ptw_req_vaddr_o), 64'h0);
    chk("rst_asid", 64'(bus.ptw_req_asid_o), 64'h0);
    chk("rst_src", 64'(bus.ptw_req_src_o), 64'h0);
    chk("rst_strobes", 64'({bus.itlb_update_valid_o, bus.dtlb_update_valid_o,
                            bus.itlb_error_o, bus.dtlb_error_o}), 64'h0);

    // Directed scenarios from the block's plan.
    txn(1, 0, 39'h0_4000_1000, 39'h0, 0, 16'h5, 0, 0, 0, 6, 0, 0);
    txn(1, 1, 39'h11_1000, 39'h22_2000, 1, 16'h1, 0, 1, 0, 2, 0, 0);  // DTLB
    txn(1, 1, 39'h11_3000, 39'h22_4000, 0, 16'h2, 0, 0, 0, 3, 0, 0);  // ITLB
    txn(1, 1, 39'h11_5000, 39'h22_6000, 1, 16'h3, 0, 0, 0, 1, 1, 0);  // DTLB
    txn(1, 0, 39'h33_0000, 39'h0, 0, 16'h4, 0, 0, 2, 3, 0, 3);        // flush in WALK cycle 3
    txn(0, 1, 39'h0, 39'h44_0000, 0, 16'h6, 0, 0, 1, 4, 0, 0);        // flush with done
    txn(1, 0, 39'h55_0000, 39'h0, 0, 16'h7, 0, 0, 4, 1, 0, 0);        // abort in REQ
    txn(0, 1, 39'h0, 39'h56_0000, 1, 16'h8, 0, 0, 0, 2, 0, 0);        // grant right after abort
    txn(0, 1, 39'h0, 39'h66_0000, 1, 16'h9, 0, 0, 3, 1, 0, 3);        // watchdog, late done
    txn(1, 1, 39'h77_0000, 39'h78_0000, 0, 16'ha, 1, 0, 5, 1, 1, 2);  // flush with handshake

    for (int n = 0; n < 200; n++) begin
      logic im, dm;
      int pick;
      pick = $urandom_range(1, 3);
      im = pick[0]; dm = pick[1];
      txn(im, dm, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), AW'($urandom),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 5),
          $urandom_range(1, WT - 1), 1'($urandom), $urandom_range(0, 3));
    end

    // Reset in mid-walk: returns to IDLE at once and clears round-robin history.
    bus.dtlb_miss_i = 1; bus.dtlb_vaddr_i = 39'h7f_0000; bus.asid_i = 16'hbeef;
    bus.dtlb_is_store_i = 1;
    rr.src = 1; rr.va = 39'h7f_0000; rr.asid = 16'hbeef; rr.st = 1;
    tick();
    bus.dtlb_miss_i = 0;
    rr.cyc = cyc; req_q.push_back(rr);
    bus.ptw_req_ready_i = 1;
    tick();
    bus.ptw_req_ready_i = 0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy_o), 64'h0);
    chk("midrst_valid", 64'(bus.ptw_req_valid_o), 64'h0);
    chk("midrst_vaddr", 64'(bus.ptw_req_vaddr_o), 64'h0);
    chk("midrst_src", 64'(bus.ptw_req_src_o), 64'h0);
    chk("midrst_store", 64'(bus.ptw_req_is_store_o), 64'h0);
    last = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    txn(1, 1, 39'h1_0000, 39'h2_0000, 0, 16'hc, 0, 0, 0, 2, 0, 0);  // DTLB wins again
    txn(1, 1, 39'h3_0000, 39'h4_0000, 0, 16'hd, 0, 0, 0, 2, 1, 0);  // then ITLB

    repeat (3) tick();
    chk("req_queue_empty", 64'(req_q.size()), 64'h0);
    chk("strobe_queue_empty", 64'(stb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlb_miss_arbiter.md
Name: tlb_miss_arbiter

Overview:
- Shares the single page-table walker (PTW) between the instruction-TLB and data-TLB miss paths.
- Grants one miss at a time with round-robin tie-break and captures the request at grant.
- Tracks the walk to completion and routes the PTW result strobe back to the TLB that missed.
- Handles SFENCE flushes and hung walks (watchdog) so a stale walk result is never written into either TLB.

Parameters:
- VLEN, 39, virtual address width.
- ASID_WIDTH, 16, address-space ID width.
- WALK_TIMEOUT, 1024, cycles in WALK before the watchdog aborts; must be ≥2.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  SFENCE.VMA flush pulse, also seen by both TLBs and the PTW.
- asid_i  in  ASID_WIDTH  current satp ASID.
- itlb_miss_i  in  1  ITLB lookup missed; held level until the TLB hits.
- itlb_vaddr_i  in  VLEN  ITLB miss address.
- dtlb_miss_i  in  1  DTLB lookup missed; held level.
- dtlb_vaddr_i  in  VLEN  DTLB miss address.
- dtlb_is_store_i  in  1  DTLB miss is a store/AMO.
- ptw_req_valid_o  out  1  walk request valid.
- ptw_req_ready_i  in  1  PTW accepts request.
- ptw_req_vaddr_o  out  VLEN  captured vaddr.
- ptw_req_asid_o  out  ASID_WIDTH  captured ASID.
- ptw_req_is_store_o  out  1  captured store flag; 0 for ITLB.
- ptw_req_src_o  out  1  0 = ITLB, 1 = DTLB.
- ptw_done_i  in  1  one-cycle walk completion.
- ptw_error_i  in  1  qualifies ptw_done_i as page fault / access fault.
- itlb_update_valid_o  out  1  ITLB may write the PTW update this cycle.
- dtlb_update_valid_o  out  1  DTLB may write the PTW update this cycle.
- itlb_error_o  out  1  ITLB walk faulted or timed out.
- dtlb_error_o  out  1  DTLB walk faulted or timed out.
- busy_o  out  1  state ≠ IDLE.

Behaviour:
- States: IDLE, REQ, WALK, DRAIN.
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - Captured vaddr, ASID, store flag and src = 0.
  - last_grant = 0 (ITLB), so the first tie goes to DTLB.
  - Watchdog counter = 0.
- IDLE:
  - Grant occurs when flush_i = 0 and any miss is asserted.
  - If only one miss is asserted, that source wins.
  - If both are asserted, the source ≠ last_grant wins.
  - On grant, capture that source's vaddr, asid_i, store flag and src; update last_grant; go to REQ next cycle.
  - flush_i in IDLE blocks grant for that cycle only.
- REQ:
  - ptw_req_valid_o = 1; request fields are stable, driven from the captured registers.
  - If ready = 1 and flush_i = 0: go to WALK and clear the counter.
  - If ready = 1 and flush_i = 1: the handshake is taken, so go to DRAIN.
  - If ready = 0 and flush_i = 1: abort to IDLE; valid drops next cycle. This is the only permitted valid-without-ready drop.
- WALK:
  - The counter increments each cycle and saturates.
  - If ptw_done_i = 1 and flush_i = 0: go to IDLE.
    - No error: raise the src update strobe.
    - ptw_error_i = 1: raise the src error strobe instead.
  - If ptw_done_i = 1 and flush_i = 1: flush wins. Suppress both strobes and go to IDLE.
  - If flush_i = 1 without done: go to DRAIN.
  - If the counter reaches WALK_TIMEOUT-1 with no done: raise the src error strobe for one cycle, then go to DRAIN.
- DRAIN:
  - All strobes are forced to 0.
  - Wait for ptw_done_i, then go to IDLE.
  - Further flush_i pulses have no effect.
- Update and error strobes:
  - Combinational in the cycle ptw_done_i is sampled; zero-latency, aligned with the PTW update data.
  - At most one strobe is high per cycle; never high outside WALK.
- Next grant is no earlier than the cycle after IDLE is entered, so TLB lookups see the newly written entry first.
- Reset mid-operation returns immediately to IDLE with outputs 0; the PTW is reset by the same rst_ni.
- Miss inputs are sampled only in IDLE. Deassertion of a miss after grant does not cancel the walk.

Test Plan:
- Single ITLB miss:
  - Stimulus: vaddr 0x0_4000_1000, asid_i 0x5; ready on the first REQ cycle; done after 6 cycles.
  - Response: ptw_req_src_o = 0, vaddr/ASID match; itlb_update_valid_o for 1 cycle in the done cycle; dtlb_update_valid_o stays 0.
- Simultaneous ITLB+DTLB misses from reset:
  - Response: DTLB granted first, then ITLB; a third simultaneous pair grants DTLB again.
- Flush during WALK:
  - Stimulus: flush_i in WALK cycle 3; done 4 cycles later.
  - Response: DRAIN entered; no strobes; busy_o falls the cycle after done.
- Flush coincident with ptw_done_i in WALK:
  - Response: both strobes 0; IDLE next cycle.
- Flush in REQ with ready = 0:
  - Response: valid drops next cycle; a new grant is possible the cycle after that.
- Watchdog with WALK_TIMEOUT = 8, DTLB store miss, no done:
  - Response: dtlb_error_o pulses after 8 WALK cycles; DRAIN holds until a late done; then IDLE.
